adder32_share_ctrl: RTL and testbench

//  Shares one 2-stage synchronous 32-bit adder (registered inputs, registered outputs) among NREQ requesters.

---
 rtl/adder32_share_ctrl_pkg.sv | 22 ++
 rtl/adder32_share_ctrl_rsp_fifo.sv | 70 +++++++
 rtl/adder32_share_ctrl.sv | 154 +++++++++++++++
 tb/tb_adder32_share_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/adder32_share_ctrl_pkg.sv
// Shared constants, types and helpers for the shared 32-bit adder controller.
// Result records are {cout, sum}; the sum bit order is [0:31] with index 0 = MSB.
package adder32_share_ctrl_pkg;

  localparam int unsigned AddW    = 32;
  localparam int unsigned Lat     = 2;
  localparam int unsigned MaxNreq = 8;

  typedef logic [0:AddW-1] word_t;
  typedef logic [AddW:0]   res_t;  // {cout, sum}

  // Full-width add with carry-in; the MSB of the result is the carry-out.
  function automatic res_t add_with_carry(word_t a, word_t b, logic cin);
    return res_t'(a) + res_t'(b) + res_t'(cin);
  endfunction

  // Increment modulo n; used for the round-robin and FIFO pointers.
  function automatic int unsigned wrap_inc(int unsigned v, int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/adder32_share_ctrl_rsp_fifo.sv
// Synchronous response FIFO of {id, cout, sum} records with an occupancy count.
// Storage is unreset; only the pointers and count are cleared by reset.
module adder32_share_ctrl_rsp_fifo
  import adder32_share_ctrl_pkg::*;
#(
  parameter int unsigned Width = 35,
  parameter int unsigned Depth = 4,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             valid_o,
  output logic [CntW-1:0]  count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_pop;

  assign valid_o = (count_q != '0);
  assign do_pop  = pop_i & valid_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = PtrW'(wrap_inc(32'(wr_ptr_q), Depth));
    end
    if (do_pop) begin
      rd_ptr_d = PtrW'(wrap_inc(32'(rd_ptr_q), Depth));
    end
    // Simultaneous push and pop leaves the count unchanged.
    unique case ({push_i, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/adder32_share_ctrl.sv
// Shares one 2-stage synchronous 32-bit adder among NReq requesters with a round-robin
// arbiter, an ID tag pipe, a credit-gated issue path and a buffered response FIFO.
module adder32_share_ctrl
  import adder32_share_ctrl_pkg::*;
#(
  parameter int unsigned NReq      = 4,
  parameter int unsigned IdW       = $clog2(NReq),
  parameter int unsigned FifoDepth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NReq-1:0]            req_valid_i,
  output logic [NReq-1:0]            req_ready_o,
  input  logic [NReq-1:0][0:AddW-1]  req_a_i,
  input  logic [NReq-1:0][0:AddW-1]  req_b_i,
  input  logic [NReq-1:0]            req_cin_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [IdW-1:0]             rsp_id_o,
  output logic [0:AddW-1]            rsp_sum_o,
  output logic                       rsp_cout_o
);

  localparam int unsigned CntW = $clog2(FifoDepth + 1);
  localparam int unsigned RspW = IdW + AddW + 1;

  logic [IdW-1:0]          ptr_q, ptr_d;
  logic                    gnt_found;
  logic [IdW-1:0]          gnt_id;
  logic [IdW-1:0]          scan_id;
  logic                    issue_ok;
  logic                    xfer;
  int unsigned             inflight;

  logic [Lat-1:0]          tag_vld_q, tag_vld_d;
  logic [Lat-1:0][IdW-1:0] tag_id_q, tag_id_d;

  word_t                   op_a, op_b;
  logic                    op_cin;
  word_t                   a_q, b_q;
  logic                    cin_q;
  res_t                    res_q;

  logic [CntW-1:0]         fifo_count;
  logic                    fifo_valid;
  logic [RspW-1:0]         fifo_rdata;
  logic                    fifo_push;
  logic                    fifo_pop;

  // Credits come from registered state only, so a pop frees its slot one cycle later.
  always_comb begin
    inflight = 0;
    for (int unsigned k = 0; k < Lat; k++) begin
      if (tag_vld_q[k]) begin
        inflight = inflight + 1;
      end
    end
    issue_ok = (inflight + 32'(fifo_count)) < FifoDepth;
  end

  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    scan_id   = '0;
    for (int unsigned k = 0; k < NReq; k++) begin
      scan_id = IdW'((32'(ptr_q) + k) % NReq);
      if (!gnt_found && req_valid_i[scan_id]) begin
        gnt_found = 1'b1;
        gnt_id    = scan_id;
      end
    end
    // Ready is held low while reset is asserted.
    xfer        = gnt_found & issue_ok & rst_ni;
    req_ready_o = '0;
    if (xfer) begin
      req_ready_o[gnt_id] = 1'b1;
    end
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = IdW'(wrap_inc(32'(gnt_id), NReq));
    end
  end

  always_comb begin
    op_a   = '0;
    op_b   = '0;
    op_cin = 1'b0;
    if (xfer) begin
      op_a   = req_a_i[gnt_id];
      op_b   = req_b_i[gnt_id];
      op_cin = req_cin_i[gnt_id];
    end
  end

  always_comb begin
    tag_vld_d    = tag_vld_q;
    tag_id_d     = tag_id_q;
    tag_vld_d[0] = xfer;
    tag_id_d[0]  = gnt_id;
    for (int unsigned k = 1; k < Lat; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_id_d[k]  = tag_id_q[k-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q     <= '0;
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      ptr_q     <= ptr_d;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
    end
  end

  // Adder datapath: unreset input and output flops, qualified by the tag pipe.
  always_ff @(posedge clk_i) begin
    a_q   <= op_a;
    b_q   <= op_b;
    cin_q <= op_cin;
    res_q <= add_with_carry(a_q, b_q, cin_q);
  end

  assign fifo_push = tag_vld_q[Lat-1];
  assign fifo_pop  = fifo_valid & rsp_ready_i;

  adder32_share_ctrl_rsp_fifo #(
    .Width (RspW),
    .Depth (FifoDepth),
    .CntW  (CntW)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .wdata_i ({tag_id_q[Lat-1], res_q}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .valid_o (fifo_valid),
    .count_o (fifo_count)
  );

  assign rsp_valid_o = fifo_valid;

  // Unreset storage never reaches the outputs while the FIFO is empty.
  always_comb begin
    {rsp_id_o, rsp_cout_o, rsp_sum_o} = '0;
    if (fifo_valid) begin
      {rsp_id_o, rsp_cout_o, rsp_sum_o} = fifo_rdata;
    end
  end

endmodule

// File: tb/tb_adder32_share_ctrl.sv
// Self-checking bench for adder32_share_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level queue model of outstanding adds.
module tb_adder32_share_ctrl;

  localparam int NREQ  = 4;
  localparam int DEPTH = 4;
  localparam int LATR  = 3;  // transfer cycle to first rsp_valid cycle

  logic             clk;
  logic             rst_n;
  logic [3:0]       req_valid;
  logic [3:0]       req_ready;
  logic [3:0][0:31] req_a;
  logic [3:0][0:31] req_b;
  logic [3:0]       req_cin;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_id;
  logic [0:31]      rsp_sum;
  logic             rsp_cout;

  adder32_share_ctrl #(
    .NReq      (NREQ),
    .IdW       (2),
    .FifoDepth (DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_cin_i   (req_cin),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_sum_o   (rsp_sum),
    .rsp_cout_o  (rsp_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [32:0] res;
    int          due;
  } op_t;

  op_t q[$];  // every add issued and not yet popped, in issue order
  int  ptr;
  int  cyc;
  int  last_xfer;
  int  n_checks;
  int  n_pass;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // One clock: compare outputs mid-cycle against the model, then advance the model.
  task automatic cycle();
    int          g;
    int          idx;
    logic [3:0]  exp_rdy;
    logic        exp_vld;
    op_t         op;
    @(negedge clk);
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (ptr + k) % NREQ;
      if (g < 0 && req_valid[idx]) g = idx;
    end
    exp_rdy = (g >= 0 && q.size() < DEPTH) ? 4'(1 << g) : 4'd0;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    exp_vld = (q.size() > 0) && (q[0].due <= cyc);
    check("rsp_valid", 64'(rsp_valid), 64'(exp_vld));
    if (exp_vld) begin
      check("rsp_id", 64'(rsp_id), 64'(q[0].id));
      check("rsp_sum", 64'(rsp_sum), 64'(q[0].res[31:0]));
      check("rsp_cout", 64'(rsp_cout), 64'(q[0].res[32]));
    end
    last_xfer = -1;
    if (exp_rdy != 4'd0) begin
      op.id  = g;
      op.res = {1'b0, 32'(req_a[g])} + {1'b0, 32'(req_b[g])} + 33'(req_cin[g]);
      op.due = cyc + LATR;
      q.push_back(op);
      ptr       = (g + 1) % NREQ;
      last_xfer = g;
    end
    if (exp_vld && rsp_ready) void'(q.pop_front());
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_word", {31'd0, rsp_id, rsp_cout, 32'(rsp_sum)}, 64'd0);
    q.delete();
    ptr = 0;
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic c);
    req_valid[i] = 1'b1;
    req_a[i]     = a;
    req_b[i]     = b;
    req_cin[i]   = c;
  endtask

  // keep=1 leaves a requester valid with the same operands after its transfer.
  task automatic run(input int n, input bit keep);
    for (int k = 0; k < n; k++) begin
      cycle();
      if (last_xfer >= 0 && !keep) req_valid[last_xfer] = 1'b0;
    end
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h0000_0000;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    cyc       = 0;
    ptr       = 0;
    last_xfer = -1;
    rst_n     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    rsp_ready = 1'b1;
    #1;
    do_reset();

    // Single op with carry-out
    set_req(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run(6, 1'b0);

    // Round-robin with all requesters continuously valid
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(i), 32'd0, 1'b0);
    run(24, 1'b1);
    req_valid = '0;
    run(6, 1'b0);

    // Backpressure: credits run out, then drain and resume
    rsp_ready = 1'b0;
    set_req(1, $urandom(), $urandom(), 1'b1);
    run(12, 1'b1);
    rsp_ready = 1'b1;
    run(10, 1'b1);
    req_valid = '0;
    run(8, 1'b0);

    // Carry-in and width corners
    set_req(2, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1);
    run(2, 1'b0);
    set_req(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run(6, 1'b0);

    // Reset with adds in flight; pending requests resume from pointer 0
    for (int i = 0; i < NREQ; i++) set_req(i, $urandom(), $urandom(), 1'($urandom()));
    run(3, 1'b0);
    do_reset();
    run(10, 1'b0);

    // Requester 3 granted, then 0 must win over 3
    req_valid = '0;
    set_req(3, 32'h1234_5678, 32'h1111_1111, 1'b0);
    run(1, 1'b0);
    set_req(0, 32'hDEAD_BEEF, 32'h0000_0001, 1'b1);
    set_req(3, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run(8, 1'b0);

    // Randomized traffic and backpressure
    for (int n = 0; n < 1500; n++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 99) < 45) begin
          set_req(i, rand_word(), rand_word(), 1'($urandom()));
        end
      end
      run(1, 1'b0);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    run(12, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
